// File: rtl/rx78_keyboard.sv
// RX-78 keyboard responder: ps2_key events -> 9x8 key matrix, Z80 port F4 (write = row strobe, read = column data).
// Latency: matrix bit updates the edge after an event; read data/dout_en registered one clock after the read cycle.
// Backpressure: none; bus cycles are sampled every clock. Optional macro RX78_JOYSTICK_EN maps joysticks to strobes 0x0A/0x0B.
module rx78_keyboard #(
  parameter logic [7:0] PORT_ADDR = 8'hF4,
  parameter int         NUM_ROWS  = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  input  logic [7:0]  joy0,
  input  logic [7:0]  joy1
);

  localparam int         IW        = $clog2(NUM_ROWS);
  localparam logic [7:0] ROWS_B    = 8'(NUM_ROWS);
  localparam logic [7:0] SHIFT_ROW = 8'd8;

  // Keymap (rx78_keymap.txt): {ext, scancode} -> {valid, row[3:0], col[2:0]}.
  // Shift keys are handled separately through hold flags, not through this table.
  function automatic logic [7:0] keymap(input logic [8:0] k);
    logic [7:0] r;
    r = 8'h00;
    case (k)
      9'h045: r = {1'b1, 4'd0, 3'd0}; 9'h016: r = {1'b1, 4'd0, 3'd1};
      9'h01E: r = {1'b1, 4'd0, 3'd2}; 9'h026: r = {1'b1, 4'd0, 3'd3};
      9'h025: r = {1'b1, 4'd0, 3'd4}; 9'h02E: r = {1'b1, 4'd0, 3'd5};
      9'h036: r = {1'b1, 4'd0, 3'd6}; 9'h03D: r = {1'b1, 4'd0, 3'd7};
      9'h03E: r = {1'b1, 4'd1, 3'd0}; 9'h046: r = {1'b1, 4'd1, 3'd1};
      9'h04C: r = {1'b1, 4'd1, 3'd2}; 9'h052: r = {1'b1, 4'd1, 3'd3};
      9'h041: r = {1'b1, 4'd1, 3'd4}; 9'h04E: r = {1'b1, 4'd1, 3'd5};
      9'h049: r = {1'b1, 4'd1, 3'd6}; 9'h04A: r = {1'b1, 4'd1, 3'd7};
      9'h054: r = {1'b1, 4'd2, 3'd0}; 9'h01C: r = {1'b1, 4'd2, 3'd1};
      9'h032: r = {1'b1, 4'd2, 3'd2}; 9'h021: r = {1'b1, 4'd2, 3'd3};
      9'h023: r = {1'b1, 4'd2, 3'd4}; 9'h024: r = {1'b1, 4'd2, 3'd5};
      9'h02B: r = {1'b1, 4'd2, 3'd6}; 9'h034: r = {1'b1, 4'd2, 3'd7};
      9'h033: r = {1'b1, 4'd3, 3'd0}; 9'h043: r = {1'b1, 4'd3, 3'd1};
      9'h03B: r = {1'b1, 4'd3, 3'd2}; 9'h042: r = {1'b1, 4'd3, 3'd3};
      9'h04B: r = {1'b1, 4'd3, 3'd4}; 9'h03A: r = {1'b1, 4'd3, 3'd5};
      9'h031: r = {1'b1, 4'd3, 3'd6}; 9'h044: r = {1'b1, 4'd3, 3'd7};
      9'h04D: r = {1'b1, 4'd4, 3'd0}; 9'h015: r = {1'b1, 4'd4, 3'd1};
      9'h02D: r = {1'b1, 4'd4, 3'd2}; 9'h01B: r = {1'b1, 4'd4, 3'd3};
      9'h02C: r = {1'b1, 4'd4, 3'd4}; 9'h03C: r = {1'b1, 4'd4, 3'd5};
      9'h02A: r = {1'b1, 4'd4, 3'd6}; 9'h01D: r = {1'b1, 4'd4, 3'd7};
      9'h022: r = {1'b1, 4'd5, 3'd0}; 9'h035: r = {1'b1, 4'd5, 3'd1};
      9'h01A: r = {1'b1, 4'd5, 3'd2}; 9'h05B: r = {1'b1, 4'd5, 3'd3};
      9'h05D: r = {1'b1, 4'd5, 3'd4}; 9'h055: r = {1'b1, 4'd5, 3'd5};
      9'h00E: r = {1'b1, 4'd5, 3'd6}; 9'h029: r = {1'b1, 4'd5, 3'd7};
      9'h05A: r = {1'b1, 4'd6, 3'd0}; 9'h066: r = {1'b1, 4'd6, 3'd1};
      9'h076: r = {1'b1, 4'd6, 3'd2}; 9'h00D: r = {1'b1, 4'd6, 3'd3};
      9'h005: r = {1'b1, 4'd6, 3'd4}; 9'h006: r = {1'b1, 4'd6, 3'd5};
      9'h004: r = {1'b1, 4'd6, 3'd6}; 9'h00C: r = {1'b1, 4'd6, 3'd7};
      9'h174: r = {1'b1, 4'd7, 3'd0}; 9'h16B: r = {1'b1, 4'd7, 3'd1};
      9'h175: r = {1'b1, 4'd7, 3'd2}; 9'h172: r = {1'b1, 4'd7, 3'd3};
      9'h16C: r = {1'b1, 4'd7, 3'd4}; 9'h171: r = {1'b1, 4'd7, 3'd5};
      9'h170: r = {1'b1, 4'd7, 3'd6}; 9'h014: r = {1'b1, 4'd7, 3'd7};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic                       tog_q, primed_q, lsh_q, rsh_q;
  logic [NUM_ROWS-1:0][7:0]   mat_q;
  logic [7:0]                 strobe_q, dout_q, row_d, row_idx, km;
  logic                       dout_en_q, key_evt, wr_hit, rd_hit;

  // primed_q masks the first clock after reset so a held toggle level is not seen as an event.
  assign key_evt = primed_q & (ps2_key[10] ^ tog_q);
  assign km      = keymap(ps2_key[8:0]);
  assign wr_hit  = ~iorq_n & ~wr_n & (addr == PORT_ADDR);
  assign rd_hit  = ~iorq_n & ~rd_n & wr_n & (addr == PORT_ADDR);
  assign row_idx = strobe_q - 8'd1;

  // Event detection and matrix / shift-flag update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
      lsh_q    <= 1'b0;
      rsh_q    <= 1'b0;
      mat_q    <= '0;
    end else begin
      tog_q    <= ps2_key[10];
      primed_q <= 1'b1;
      if (key_evt) begin
        if (ps2_key[8:0] == 9'h012) begin
          lsh_q <= ps2_key[9];
        end else if (ps2_key[8:0] == 9'h059) begin
          rsh_q <= ps2_key[9];
        end else if (km[7]) begin
          mat_q[km[6:3]][km[2:0]] <= ps2_key[9];
        end
      end
    end
  end

`ifdef RX78_JOYSTICK_EN
  logic [7:0] joy0_m_q, joy0_s_q, joy1_m_q, joy1_s_q;

  // Two-flop synchronizers for the asynchronous joystick inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy0_m_q <= 8'h00;
      joy0_s_q <= 8'h00;
      joy1_m_q <= 8'h00;
      joy1_s_q <= 8'h00;
    end else begin
      joy0_m_q <= joy0;
      joy0_s_q <= joy0_m_q;
      joy1_m_q <= joy1;
      joy1_s_q <= joy1_m_q;
    end
  end
`else
  logic unused_joy;
  assign unused_joy = ^{joy0, joy1};
`endif

  // Row mux: strobe 1..NUM_ROWS selects a matrix row; row 8 bit 0 is the OR of both shift flags.
  always_comb begin
    row_d = 8'h00;
    if (strobe_q >= 8'd1 && strobe_q <= ROWS_B) begin
      row_d = mat_q[row_idx[IW-1:0]];
      if (row_idx == SHIFT_ROW) row_d[0] = row_d[0] | lsh_q | rsh_q;
    end
`ifdef RX78_JOYSTICK_EN
    else if (strobe_q == 8'h0A) begin
      row_d = joy0_s_q;
    end else if (strobe_q == 8'h0B) begin
      row_d = joy1_s_q;
    end
`endif
  end

  // Port F4 strobe latch and registered read response; a write with rd_n also low never answers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q  <= 8'h00;
      dout_q    <= 8'h00;
      dout_en_q <= 1'b0;
    end else begin
      if (wr_hit) strobe_q <= din;
      dout_q    <= rd_hit ? row_d : 8'h00;
      dout_en_q <= rd_hit;
    end
  end

  assign dout    = dout_q;
  assign dout_en = dout_en_q;

endmodule

// File: tb/tb_rx78_keyboard.sv
// Self-checking bench for rx78_keyboard: directed steps plus randomized key events and row reads.
// Expected rows come from a small key-state model (held-key bits and held-shift set).
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_rx78_keyboard;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = 11'h400;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  addr = 8'h00, din = 8'h00;
  logic [7:0]  dout;
  logic        dout_en;
  logic [7:0]  joy0 = 8'h22, joy1 = 8'h11;

  int checks = 0;
  int failures = 0;

  // Model: key bits by (row, col), and which shift keys are held.
  bit mdl_mat [0:8][0:7];
  bit mdl_lsh, mdl_rsh;

  rx78_keyboard dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .din(din), .dout(dout), .dout_en(dout_en),
    .joy0(joy0), .joy1(joy1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mdl_row(input logic [7:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (s >= 8'd1 && s <= 8'd9) begin
      for (int c = 0; c < 8; c++) r[c] = mdl_mat[s - 1][c];
      if (s == 8'd9) r[0] = r[0] | mdl_lsh | mdl_rsh;
    end
`ifdef RX78_JOYSTICK_EN
    else if (s == 8'h0A) r = joy0;
    else if (s == 8'h0B) r = joy1;
`endif
    return r;
  endfunction

  task automatic model_event(input bit press, input bit ext, input logic [7:0] code);
    if (!ext && code == 8'h12) mdl_lsh = press;
    else if (!ext && code == 8'h59) mdl_rsh = press;
    else if (!ext && code == 8'h1C) mdl_mat[2][1] = press;
    else if (ext && code == 8'h75) mdl_mat[7][2] = press;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 9; r++) for (int c = 0; c < 8; c++) mdl_mat[r][c] = 1'b0;
    mdl_lsh = 1'b0;
    mdl_rsh = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 8'h00; din = 8'h00;
  endtask

  task automatic send_key(input bit press, input bit ext, input logic [7:0] code);
    @(negedge clk);
    ps2_key = {~ps2_key[10], press, ext, code};
    model_event(press, ext, code);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr_port(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    iorq_n = 1'b0; wr_n = 1'b0; addr = a; din = v;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd_port(input logic [7:0] a, output logic [7:0] d, output logic en);
    @(negedge clk);
    iorq_n = 1'b0; rd_n = 1'b0; addr = a;
    @(posedge clk);
    #1;
    d = dout;
    en = dout_en;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd_check(input string tag, input logic [7:0] s);
    logic [7:0] d;
    logic       en;
    wr_port(8'hF4, s);
    rd_port(8'hF4, d, en);
    chk({tag, "_en"}, {7'b0, en}, 8'h01);
    chk(tag, d, mdl_row(s));
  endtask

  initial begin
    logic [7:0] d, old;
    logic       en;
    logic [7:0] code_t [7];
    bit         ext_t  [7];
    int         pick;
    bit         press;
    logic [7:0] s;

    code_t = '{8'h1C, 8'h75, 8'h12, 8'h59, 8'h75, 8'h1C, 8'h00};
    ext_t  = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
    model_clear();
    idle_bus();

    // Reset with toggle bit held high.
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_en", {7'b0, dout_en}, 8'h00);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Read latency: response appears one clock after the read starts.
    wr_port(8'hF4, 8'h03);
    @(negedge clk);
    iorq_n = 1'b0; rd_n = 1'b0; addr = 8'hF4;
    #1;
    chk("rd_pre_edge_en", {7'b0, dout_en}, 8'h00);
    @(posedge clk);
    #1;
    chk("rd_lat_en", {7'b0, dout_en}, 8'h01);
    chk("rd_no_spurious", dout, 8'h00);
    @(negedge clk);
    idle_bus();
    @(posedge clk);
    #1;
    chk("rd_end_en", {7'b0, dout_en}, 8'h00);

    // A press/release.
    send_key(1'b1, 1'b0, 8'h1C);
    rd_check("a_press", 8'h03);
    send_key(1'b0, 1'b0, 8'h1C);
    rd_check("a_release", 8'h03);

    // Shift pair hold flags.
    send_key(1'b1, 1'b0, 8'h12);
    send_key(1'b1, 1'b0, 8'h59);
    send_key(1'b0, 1'b0, 8'h12);
    rd_check("shift_one_held", 8'h09);
    send_key(1'b0, 1'b0, 8'h59);
    rd_check("shift_none", 8'h09);

    // Extended vs plain 0x75.
    send_key(1'b1, 1'b1, 8'h75);
    rd_check("up_press", 8'h08);
    send_key(1'b0, 1'b1, 8'h75);
    send_key(1'b1, 1'b0, 8'h75);
    rd_check("kp8_no_up", 8'h08);
    send_key(1'b0, 1'b0, 8'h75);

    // Event in the same cycle as a read: old row first, new row next.
    wr_port(8'hF4, 8'h03);
    @(negedge clk);
    old = mdl_row(8'h03);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    model_event(1'b1, 1'b0, 8'h1C);
    iorq_n = 1'b0; rd_n = 1'b0; addr = 8'hF4;
    @(posedge clk);
    #1;
    chk("simul_old", dout, old);
    @(posedge clk);
    #1;
    chk("simul_new", dout, mdl_row(8'h03));
    @(negedge clk);
    idle_bus();

    // Wrong address.
    rd_port(8'hF5, d, en);
    chk("f5_en", {7'b0, en}, 8'h00);
    chk("f5_dout", d, 8'h00);

    // rd_n and wr_n both low: write only.
    @(negedge clk);
    iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; addr = 8'hF4; din = 8'h09;
    @(posedge clk);
    #1;
    chk("rdwr_no_en", {7'b0, dout_en}, 8'h00);
    @(negedge clk);
    idle_bus();
    send_key(1'b1, 1'b0, 8'h59);
    rd_port(8'hF4, d, en);
    chk("rdwr_strobe_took", d, mdl_row(8'h09));
    send_key(1'b0, 1'b0, 8'h59);

    // Unlisted strobes and joystick strobes.
    repeat (4) @(negedge clk);
    rd_check("strobe0", 8'h00);
    rd_check("strobe0c", 8'h0C);
    rd_check("strobeff", 8'hFF);
    rd_check("joy0", 8'h0A);
    rd_check("joy1", 8'h0B);

    // Randomized key events and row reads.
    for (int i = 0; i < 150; i++) begin
      pick  = $urandom_range(0, 6);
      press = 1'($urandom_range(0, 1));
      send_key(press, ext_t[pick], code_t[pick]);
      s = 8'($urandom_range(0, 11));
      rd_check("rand", s);
    end

    // Reset asserted mid-read drops dout_en at once and clears the matrix.
    send_key(1'b1, 1'b0, 8'h1C);
    wr_port(8'hF4, 8'h03);
    @(negedge clk);
    iorq_n = 1'b0; rd_n = 1'b0; addr = 8'hF4;
    @(posedge clk);
    #1;
    chk("pre_rst_dout", dout, 8'h02);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_en", {7'b0, dout_en}, 8'h00);
    chk("async_rst_dout", dout, 8'h00);
    model_clear();
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_check("post_rst_row", 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
